// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input stream and result output port of product_accumulator
interface product_accumulator_if #(
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums N_TERMS 8-bit products and presents each sum on a valid/ready port
// ACC_SATURATE_EN: clamp the accumulator at all-ones instead of wrapping modulo 2^ACC_W.
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  clr,
  product_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, next_state;
  logic [ACC_W-1:0] acc, acc_next, sum_q;
  logic [ACC_W:0]   raw_sum;
  logic [CNT_W-1:0] cnt;
  logic             ovf, ovf_q, valid_q;
  logic             carry, in_ready, in_accept, step, finish;

  assign raw_sum = {1'b0, acc} + {1'b0, ACC_W'(bus.in_product)};
  assign carry   = raw_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // Once clamped, acc stays all-ones: any further nonzero product carries again.
  assign acc_next = carry ? '1 : raw_sum[ACC_W-1:0];
`else
  assign acc_next = raw_sum[ACC_W-1:0];
`endif

  assign in_ready  = (state == ACCUM);
  assign in_accept = bus.in_valid && in_ready;

  always_comb begin
    next_state = state;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      ACCUM: begin
        if (in_accept) begin
          if (cnt == LAST) begin
            finish     = 1'b1;
            next_state = HOLD;
          end else begin
            step = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) next_state = ACCUM;
      end
      default: next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      // Abort keeps the last out_sum/out_ovf values but withdraws out_valid.
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= next_state;
      valid_q <= (next_state == HOLD);
      if (step) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
        ovf <= ovf | carry;
      end
      if (finish) begin
        sum_q <= acc_next;
        ovf_q <= ovf | carry;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator in three configurations
module tb_product_accumulator;
  localparam int NT [3] = '{4, 2, 1};
  localparam int AW [3] = '{16, 8, 8};

  typedef struct {
    int sum;
    int ovf;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid_a  [3];
  logic [7:0]  prod_a      [3];
  logic        out_ready_a [3];
  logic        clr_a       [3];
  logic        in_ready_a  [3];
  logic        out_valid_a [3];
  logic        out_ovf_a   [3];
  logic [15:0] sum_a       [3];
  int          rdy_mode    [3];

  exp_t ebuf [3][256];
  int   wr [3], rd [3], part_total [3], part_n [3];
  bit   holding [3], drop [3];
  exp_t cur [3];
  int   n_checks = 0, n_fail = 0;
  int   a1, a2;

  product_accumulator_if #(.ACC_W(16)) bus0 ();
  product_accumulator_if #(.ACC_W(8))  bus1 ();
  product_accumulator_if #(.ACC_W(8))  bus2 ();

  assign bus0.in_valid = in_valid_a[0];
  assign bus0.in_product = prod_a[0];
  assign bus0.out_ready = out_ready_a[0];
  assign in_ready_a[0] = bus0.in_ready;
  assign out_valid_a[0] = bus0.out_valid;
  assign out_ovf_a[0] = bus0.out_ovf;
  assign sum_a[0] = bus0.out_sum;

  assign bus1.in_valid = in_valid_a[1];
  assign bus1.in_product = prod_a[1];
  assign bus1.out_ready = out_ready_a[1];
  assign in_ready_a[1] = bus1.in_ready;
  assign out_valid_a[1] = bus1.out_valid;
  assign out_ovf_a[1] = bus1.out_ovf;
  assign sum_a[1] = {8'h00, bus1.out_sum};

  assign bus2.in_valid = in_valid_a[2];
  assign bus2.in_product = prod_a[2];
  assign bus2.out_ready = out_ready_a[2];
  assign in_ready_a[2] = bus2.in_ready;
  assign out_valid_a[2] = bus2.out_valid;
  assign out_ovf_a[2] = bus2.out_ovf;
  assign sum_a[2] = {8'h00, bus2.out_sum};

  product_accumulator #(.N_TERMS(4), .ACC_W(16)) u0 (.clk(clk), .rst(rst), .clr(clr_a[0]), .bus(bus0));
  product_accumulator #(.N_TERMS(2), .ACC_W(8))  u1 (.clk(clk), .rst(rst), .clr(clr_a[1]), .bus(bus1));
  product_accumulator #(.N_TERMS(1), .ACC_W(8))  u2 (.clk(clk), .rst(rst), .clr(clr_a[2]), .bus(bus2));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d]: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  // Reference: a result is the plain sum of the last N_TERMS accepted products.
  task automatic model_accept(input int k, input int p);
    int   maxv;
    exp_t e;
    part_total[k] += p;
    part_n[k]++;
    if (part_n[k] == NT[k]) begin
      maxv  = (1 << AW[k]) - 1;
      e.ovf = (part_total[k] > maxv) ? 1 : 0;
`ifdef ACC_SATURATE_EN
      e.sum = (e.ovf == 1) ? maxv : part_total[k];
`else
      e.sum = part_total[k] % (maxv + 1);
`endif
      e.cyc = cyc;
      ebuf[k][wr[k] % 256] = e;
      wr[k]++;
      part_total[k] = 0;
      part_n[k] = 0;
    end
  endtask

  task automatic send(input int k, input int p, input bit do_clr);
    int t = 0;
    in_valid_a[k] = 1'b1;
    prod_a[k] = p[7:0];
    while (in_ready_a[k] !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", k, 32'(in_ready_a[k]), 32'd1);
    clr_a[k] = do_clr;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    clr_a[k] = 1'b0;
    if (do_clr) begin
      part_total[k] = 0;
      part_n[k] = 0;
    end else begin
      model_accept(k, p);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_run(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      int p;
      bit c;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      idle(gap);
      p = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      c = (k == 0) && ($urandom_range(0, 19) == 0);
      send(k, p, c);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rdy_mode[k] == 0) out_ready_a[k] = 1'b1;
      else if (rdy_mode[k] == 1) out_ready_a[k] = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: pops one expected result per rising out_valid, then tracks it until accepted.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (drop[k]) begin
        chk("valid_drop", k, 32'(out_valid_a[k]), 32'd0);
        drop[k] = 1'b0;
      end else if (out_valid_a[k] === 1'b1) begin
        if (!holding[k]) begin
          chk("result_expected", k, 32'(wr[k] != rd[k]), 32'd1);
          if (wr[k] != rd[k]) begin
            cur[k] = ebuf[k][rd[k] % 256];
            rd[k]++;
            chk("out_sum", k, 32'(sum_a[k]), cur[k].sum);
            chk("out_ovf", k, 32'(out_ovf_a[k]), cur[k].ovf);
            chk("latency", k, cyc, cur[k].cyc);
            holding[k] = 1'b1;
          end
        end else begin
          chk("sum_stable", k, 32'(sum_a[k]), cur[k].sum);
          chk("ovf_stable", k, 32'(out_ovf_a[k]), cur[k].ovf);
        end
        chk("in_ready_in_hold", k, 32'(in_ready_a[k]), 32'd0);
        if (out_ready_a[k] === 1'b1) begin
          holding[k] = 1'b0;
          drop[k] = 1'b1;
        end
      end
      if (rst === 1'b1 || clr_a[k] === 1'b1) begin
        holding[k] = 1'b0;
        drop[k] = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    int t;
    for (int k = 0; k < 3; k++) begin
      in_valid_a[k] = 1'b0;
      prod_a[k] = 8'd0;
      out_ready_a[k] = 1'b1;
      clr_a[k] = 1'b0;
      rdy_mode[k] = 0;
      wr[k] = 0;
      rd[k] = 0;
      part_total[k] = 0;
      part_n[k] = 0;
      holding[k] = 1'b0;
      drop[k] = 1'b0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("reset_out_valid", k, 32'(out_valid_a[k]), 32'd0);
      chk("reset_in_ready", k, 32'(in_ready_a[k]), 32'd1);
      chk("reset_out_sum", k, 32'(sum_a[k]), 32'd0);
      chk("reset_out_ovf", k, 32'(out_ovf_a[k]), 32'd0);
    end

    send(0, 6, 0); send(0, 15, 0); send(0, 225, 0); send(0, 0, 0);
    idle(3);

    // Backpressure: result held while a new product waits with in_valid high.
    rdy_mode[0] = 2;
    out_ready_a[0] = 1'b0;
    send(0, 6, 0); send(0, 15, 0); send(0, 225, 0); send(0, 0, 0);
    fork
      repeat (4) send(0, 15, 0);
      begin
        idle(5);
        out_ready_a[0] = 1'b1;
        idle(1);
        out_ready_a[0] = 1'b0;
      end
    join
    idle(2);
    rdy_mode[0] = 0;
    idle(3);

    send(0, 6, 0); send(0, 15, 0); send(0, 225, 1);
    send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 0);
    idle(3);

    // Reset while a result is pending.
    rdy_mode[0] = 2;
    out_ready_a[0] = 1'b0;
    repeat (4) send(0, 1, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_hold_out_valid", 0, 32'(out_valid_a[0]), 32'd0);
    chk("rst_hold_out_sum", 0, 32'(sum_a[0]), 32'd0);
    chk("rst_hold_out_ovf", 0, 32'(out_ovf_a[0]), 32'd0);
    chk("rst_hold_in_ready", 0, 32'(in_ready_a[0]), 32'd1);
    rdy_mode[0] = 0;
    repeat (4) send(0, 1, 0);
    idle(3);

    send(1, 225, 0); send(1, 225, 0); send(1, 1, 0); send(1, 2, 0);
    idle(3);

    send(2, 7, 0);
    a1 = cyc;
    send(2, 9, 0);
    a2 = cyc;
    chk("single_term_spacing", 2, a2 - a1, 32'd2);
    idle(3);

    for (int k = 0; k < 3; k++) rdy_mode[k] = 1;
    fork
      rand_run(0, 200);
      rand_run(1, 80);
      rand_run(2, 60);
    join
    for (int k = 0; k < 3; k++) rdy_mode[k] = 0;

    t = 0;
    while (t < 500 && (wr[0] != rd[0] || wr[1] != rd[1] || wr[2] != rd[2] ||
                       holding[0] || holding[1] || holding[2])) begin
      @(negedge clk);
      t++;
    end
    idle(2);
    for (int k = 0; k < 3; k++) begin
      chk("drained_results", k, wr[k] - rd[k], 32'd0);
      chk("drained_hold", k, 32'(holding[k]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
